// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus for mem_port_arbiter: one instance per port (CPU, DMA).
// master = requester, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              stall;

  modport master (output req, we, addr, wdata, input rdata, ack, stall);
  modport slave  (input req, we, addr, wdata, output rdata, ack, stall);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port RAM between the CPU and DMA ports.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> RESP (one-cycle ack).
// Optional build macro ARB_RR_EN: round-robin on simultaneous requests
// (default: fixed CPU priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave dma,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant_dma;
`ifdef ARB_RR_EN
  logic              granted_q, granted_d;
`endif

  // Arbitration: decides whether DMA wins when the FSM is in IDLE.
  always_comb begin
`ifdef ARB_RR_EN
    if (cpu.req && dma.req) begin
      grant_dma = granted_q ? ~owner_q : 1'b0;
    end else begin
      grant_dma = dma.req;
    end
`else
    grant_dma = ~cpu.req;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    busy_d      = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef ARB_RR_EN
    granted_d   = granted_q;
`endif
    case (state_q)
      IDLE: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (cpu.req || dma.req) begin
          owner_d     = grant_dma;
          we_d        = grant_dma ? dma.we : cpu.we;
          mem_addr_d  = grant_dma ? dma.addr : cpu.addr;
          mem_wdata_d = grant_dma ? dma.wdata : cpu.wdata;
          cnt_d       = CNT_W'(WAIT_STATES);
          mem_we_d    = we_d;
          mem_re_d    = ~we_d;
          busy_d      = 1'b1;
          state_d     = ACCESS;
`ifdef ARB_RR_EN
          granted_d   = 1'b1;
`endif
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          // Last access cycle: capture read data and move to the ack cycle.
          if (!we_q) begin
            if (owner_q) begin
              dma_rdata_d = mem_rdata;
            end else begin
              cpu_rdata_d = mem_rdata;
            end
          end
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          cpu_ack_d   = ~owner_q;
          dma_ack_d   = owner_q;
          state_d     = RESP;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_re_d = ~we_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the RAM strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_RR_EN
      granted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef ARB_RR_EN
      granted_q   <= granted_d;
`endif
    end
  end

  assign cpu.rdata = cpu_rdata_q;
  assign cpu.ack   = cpu_ack_q;
  assign cpu.stall = cpu.req & ~cpu_ack_q;
  assign dma.rdata = dma_rdata_q;
  assign dma.ack   = dma_ack_q;
  assign dma.stall = dma.req & ~dma_ack_q;

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (RAM array, per-port read results,
// last-grant tracking).
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WS     = 1;
  localparam int          LAT    = int'(WS) + 2;
  localparam int          DEPTH  = 1 << ADDR_W;
`ifdef ARB_RR_EN
  localparam int CONT_CPU = 2;
`else
  localparam int CONT_CPU = 4;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we, mem_re, owner, busy;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dma_bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu       (cpu_bus),
    .dma       (dma_bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with a bench-side preload port.
  logic [DATA_W-1:0] ram [DEPTH];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [DATA_W-1:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_rdata [2];
  logic              last_owner;
  bit                seen;
  int                checks = 0;
  int                errors = 0;

  function automatic logic model_winner();
`ifdef ARB_RR_EN
    return seen ? ~last_owner : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_apply(input logic p, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
    if (w) ref_mem[a] = d;
    else exp_rdata[p] = ref_mem[a];
    last_owner = p;
    seen       = 1'b1;
  endtask

  task automatic model_reset();
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_owner   = 1'b0;
    seen         = 1'b0;
  endtask

  function automatic logic ack_of(input logic p);
    return p ? dma_bus.ack : cpu_bus.ack;
  endfunction

  function automatic logic stall_of(input logic p);
    return p ? dma_bus.stall : cpu_bus.stall;
  endfunction

  function automatic logic [DATA_W-1:0] rdata_of(input logic p);
    return p ? dma_bus.rdata : cpu_bus.rdata;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    if (p) begin
      dma_bus.req = r; dma_bus.we = w; dma_bus.addr = a; dma_bus.wdata = d;
    end else begin
      cpu_bus.req = r; cpu_bus.we = w; cpu_bus.addr = a; cpu_bus.wdata = d;
    end
  endtask

  task automatic drop(input logic p);
    if (p) dma_bus.req = 1'b0;
    else cpu_bus.req = 1'b0;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    poke_addr  = a;
    poke_data  = d;
    poke_en    = 1'b1;
    step();
    poke_en    = 1'b0;
    ref_mem[a] = d;
  endtask

  // One access from port p starting in an IDLE cycle (cycle 0); records per-cycle strobes.
  task automatic do_access(input logic p, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, output int ack_c,
                           output logic [15:0] re_m, output logic [15:0] we_m,
                           output logic [15:0] st_m, output int oth);
    bit done;
    done = 1'b0; ack_c = -1; re_m = '0; we_m = '0; st_m = '0; oth = 0;
    drive(p, 1'b1, w, a, d);
    #1;
    st_m[0] = stall_of(p);
    for (int c = 1; c < 16 && !done; c++) begin
      step();
      re_m[c] = mem_re;
      we_m[c] = mem_we;
      st_m[c] = stall_of(p);
      if (ack_of(!p)) oth++;
      if (ack_of(p)) begin
        ack_c = c;
        done  = 1'b1;
      end
    end
    drop(p);
    if (done) model_apply(p, w, a, d);
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({mem_we, mem_re, busy, owner, cpu_bus.ack, dma_bus.ack, cpu_bus.stall, dma_bus.stall} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000",
               {mem_we, mem_re, busy, owner, cpu_bus.ack, dma_bus.ack, cpu_bus.stall, dma_bus.stall});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (cpu_bus.rdata !== '0 || dma_bus.rdata !== '0) begin
      errors++;
      $display("FAIL reset_rdata got cpu=%h dma=%h want 0", cpu_bus.rdata, dma_bus.rdata);
    end
    reset_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_cpu_read();
    int ack_c, oth;
    logic [15:0] re_m, we_m, st_m;
    poke(ADDR_W'(5), 32'h1234_5678);
    do_access(1'b0, 1'b0, ADDR_W'(5), '0, ack_c, re_m, we_m, st_m, oth);
    checks++;
    if (ack_c !== LAT) begin errors++; $display("FAIL cpu_read_ack_cycle got %0d want %0d", ack_c, LAT); end
    checks++;
    if (re_m !== 16'(((1 << (WS + 1)) - 1) << 1)) begin
      errors++; $display("FAIL cpu_read_re_cycles got %h want %h", re_m, 16'(((1 << (WS + 1)) - 1) << 1));
    end
    checks++;
    if (we_m !== 16'h0) begin errors++; $display("FAIL cpu_read_we_cycles got %h want 0", we_m); end
    checks++;
    if (st_m !== 16'((1 << (WS + 2)) - 1)) begin
      errors++; $display("FAIL cpu_read_stall got %h want %h", st_m, 16'((1 << (WS + 2)) - 1));
    end
    checks++;
    if (oth !== 0) begin errors++; $display("FAIL cpu_read_dma_ack got %0d want 0", oth); end
    checks++;
    if (cpu_bus.rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL cpu_read_data got %h want 12345678", cpu_bus.rdata);
    end
  endtask

  task automatic test_dma_write();
    int ack_c, oth;
    logic [15:0] re_m, we_m, st_m;
    do_access(1'b1, 1'b1, ADDR_W'(9'h0AA), 32'hDEAD_BEEF, ack_c, re_m, we_m, st_m, oth);
    checks++;
    if (ack_c !== LAT) begin errors++; $display("FAIL dma_write_ack_cycle got %0d want %0d", ack_c, LAT); end
    checks++;
    if (we_m !== 16'h0002 || re_m !== 16'h0) begin
      errors++; $display("FAIL dma_write_strobes got we=%h re=%h want we=0002 re=0000", we_m, re_m);
    end
    checks++;
    if (oth !== 0) begin errors++; $display("FAIL dma_write_cpu_ack got %0d want 0", oth); end
    do_access(1'b0, 1'b0, ADDR_W'(9'h0AA), '0, ack_c, re_m, we_m, st_m, oth);
    checks++;
    if (cpu_bus.rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL dma_write_readback got %h want deadbeef", cpu_bus.rdata);
    end
    checks++;
    if (dma_bus.rdata !== '0) begin errors++; $display("FAIL dma_rdata_kept got %h want 0", dma_bus.rdata); end
  endtask

  task automatic test_contention();
    logic first;
    int ack_c[2];
    logic own_c[2];
    logic [ADDR_W-1:0] a[2];
    first = model_winner();
    for (int i = 0; i < 2; i++) begin
      ack_c[i] = -1;
      own_c[i] = 1'b0;
      a[i]     = ADDR_W'($urandom_range(0, 31));
    end
    drive(1'b0, 1'b1, 1'b0, a[0], '0);
    drive(1'b1, 1'b1, 1'b0, a[1], '0);
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (ack_of(1'(i)) && ack_c[i] < 0) begin
          ack_c[i] = c;
          own_c[i] = owner;
          model_apply(1'(i), 1'b0, a[i], '0);
          drop(1'(i));
        end
      end
    end
    drop(1'b0);
    drop(1'b1);
    checks++;
    if (ack_c[first] !== LAT) begin
      errors++; $display("FAIL contend_first_ack port=%0d got %0d want %0d", first, ack_c[first], LAT);
    end
    checks++;
    if (ack_c[!first] !== 2 * LAT + 1) begin
      errors++; $display("FAIL contend_second_ack port=%0d got %0d want %0d", !first, ack_c[!first], 2 * LAT + 1);
    end
    checks++;
    if (own_c[0] !== 1'b0 || own_c[1] !== 1'b1) begin
      errors++; $display("FAIL contend_owner got cpu=%b dma=%b want 0 1", own_c[0], own_c[1]);
    end
    checks++;
    if (cpu_bus.rdata !== exp_rdata[0] || dma_bus.rdata !== exp_rdata[1]) begin
      errors++; $display("FAIL contend_rdata got %h %h want %h %h", cpu_bus.rdata, dma_bus.rdata,
                         exp_rdata[0], exp_rdata[1]);
    end
  endtask

  task automatic test_continuous();
    logic [ADDR_W-1:0] a[2];
    int n_ack;
    int n_p[2];
    logic got_p, exp_p;
    n_ack = 0;
    n_p[0] = 0;
    n_p[1] = 0;
    a[0] = ADDR_W'($urandom_range(0, 31));
    a[1] = ADDR_W'($urandom_range(0, 31));
    drive(1'b0, 1'b1, 1'b0, a[0], '0);
    drive(1'b1, 1'b1, 1'b0, a[1], '0);
    for (int c = 1; c <= 4 * (LAT + 1) + 6 && n_ack < 4; c++) begin
      step();
      if (cpu_bus.ack || dma_bus.ack) begin
        got_p = dma_bus.ack;
        exp_p = model_winner();
        checks++;
        if (got_p !== exp_p) begin errors++; $display("FAIL cont_order idx=%0d got %0d want %0d", n_ack, got_p, exp_p); end
        checks++;
        if (c !== n_ack * (LAT + 1) + LAT) begin
          errors++; $display("FAIL cont_ack_cycle idx=%0d got %0d want %0d", n_ack, c, n_ack * (LAT + 1) + LAT);
        end
        model_apply(got_p, 1'b0, a[got_p], '0);
        checks++;
        if (rdata_of(got_p) !== exp_rdata[got_p]) begin
          errors++; $display("FAIL cont_rdata got %h want %h", rdata_of(got_p), exp_rdata[got_p]);
        end
        n_p[got_p]++;
        n_ack++;
        if (n_ack == 4) begin
          drop(1'b0);
          drop(1'b1);
        end
      end
    end
    drop(1'b0);
    drop(1'b1);
    checks++;
    if (n_ack !== 4 || n_p[0] !== CONT_CPU) begin
      errors++; $display("FAIL cont_counts got acks=%0d cpu=%0d want 4 %0d", n_ack, n_p[0], CONT_CPU);
    end
    step();
  endtask

  task automatic test_reset_mid_access();
    int n_ack, ack_c, oth;
    logic [15:0] re_m, we_m, st_m;
    logic [ADDR_W-1:0] ra;
    drive(1'b0, 1'b1, 1'b1, ADDR_W'(9'h033), $urandom);
    step();
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we got %b want 1", mem_we); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_re, busy, cpu_bus.ack} !== 4'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL rst_async got we/re/busy/ack=%b addr=%h want 0000 0",
                         {mem_we, mem_re, busy, cpu_bus.ack}, mem_addr);
    end
    drop(1'b0);
    model_reset();
    n_ack = 0;
    repeat (2) begin step(); if (cpu_bus.ack) n_ack++; end
    reset_n = 1'b1;
    repeat (2) begin step(); if (cpu_bus.ack || busy) n_ack++; end
    checks++;
    if (n_ack !== 0 || cpu_bus.rdata !== '0) begin
      errors++; $display("FAIL rst_no_ack got acks=%0d rdata=%h want 0 0", n_ack, cpu_bus.rdata);
    end
    ra = ADDR_W'($urandom_range(0, 31));
    do_access(1'b0, 1'b0, ra, '0, ack_c, re_m, we_m, st_m, oth);
    checks++;
    if (ack_c !== LAT || cpu_bus.rdata !== exp_rdata[0]) begin
      errors++; $display("FAIL rst_after_read got ack=%0d data=%h want %0d %h", ack_c, cpu_bus.rdata,
                         LAT, exp_rdata[0]);
    end
  endtask

  task automatic test_drop_req();
    int ack_c, busy_after;
    poke(ADDR_W'(9'h010), 32'h0000_BEEF);
    ack_c = -1;
    busy_after = 0;
    drive(1'b0, 1'b1, 1'b0, ADDR_W'(9'h010), '0);
    step();
    drop(1'b0);
    for (int c = 2; c <= LAT + 4; c++) begin
      step();
      if (cpu_bus.ack || dma_bus.ack) ack_c = c;
      if (c > LAT && busy) busy_after++;
    end
    model_apply(1'b0, 1'b0, ADDR_W'(9'h010), '0);
    checks++;
    if (ack_c !== LAT) begin errors++; $display("FAIL drop_ack_cycle got %0d want %0d", ack_c, LAT); end
    checks++;
    if (cpu_bus.rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL drop_rdata got %h want 0000beef", cpu_bus.rdata); end
    checks++;
    if (busy_after !== 0) begin errors++; $display("FAIL drop_stays_idle got busy cycles %0d want 0", busy_after); end
  endtask

  task automatic test_random();
    int mode;
    logic act[2];
    logic r_we[2];
    logic [ADDR_W-1:0] r_addr[2];
    logic [DATA_W-1:0] r_data[2];
    int exp_c[2];
    logic w, got, want;
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 2));
      act[0] = (mode != 1);
      act[1] = (mode != 0);
      for (int i = 0; i < 2; i++) begin
        r_we[i]   = 1'($urandom_range(0, 1));
        r_addr[i] = ADDR_W'($urandom_range(0, 31));
        r_data[i] = $urandom;
        exp_c[i]  = act[i] ? LAT : -1;
      end
      if (act[0] && act[1]) begin
        w = model_winner();
        exp_c[w]  = LAT;
        exp_c[!w] = 2 * LAT + 1;
      end
      for (int i = 0; i < 2; i++) if (act[i]) drive(1'(i), 1'b1, r_we[i], r_addr[i], r_data[i]);
      for (int c = 1; c <= 2 * LAT + 3; c++) begin
        step();
        for (int i = 0; i < 2; i++) begin
          got  = ack_of(1'(i));
          want = (c == exp_c[i]);
          checks++;
          if (got !== want) begin
            errors++; $display("FAIL rand_ack it=%0d port=%0d cycle=%0d got %b want %b", it, i, c, got, want);
          end
          if (got) begin
            model_apply(1'(i), r_we[i], r_addr[i], r_data[i]);
            checks++;
            if (rdata_of(1'(i)) !== exp_rdata[i] || owner !== 1'(i)) begin
              errors++; $display("FAIL rand_result it=%0d port=%0d got data=%h owner=%b want %h %0d", it, i,
                                 rdata_of(1'(i)), owner, exp_rdata[i], i);
            end
            drop(1'(i));
          end
        end
      end
      drop(1'b0);
      drop(1'b1);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    model_reset();
    for (int i = 0; i < 32; i++) poke(ADDR_W'(i), $urandom);
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_continuous();
    test_reset_mid_access();
    test_contention();
    test_drop_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between the CPU control path and a DMA/debug loader port.
- The CPU side carries the control unit's Read/write_mem traffic through MAR/MDR. The DMA side is used for program load and memory inspection while the CPU runs or is stopped.
- Sequences each access through a wait-state counter, returns registered read data, and gives each requester a one-cycle ack.
- The CPU side uses cpu_stall to hold its state machine until the access completes.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data width
WAIT_STATES, 1, extra RAM cycles per access beyond the first; legal range 0..15

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level; held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  registered CPU read data
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  same widths/meaning for the DMA port
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read enable
mem_rdata  in  DATA_W  RAM read data, synchronous, valid one cycle after address
owner  out  1  0=CPU, 1=DMA; port of the current/last grant
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, wait counter=0, owner=0.
  - cpu_rdata=dma_rdata=0; all acks, mem_we, mem_re, busy low.
  - mem_addr and mem_wdata are 0.
  - mem_we drops immediately, even mid-access.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - mem_* outputs are 0.
  - At the clock edge, if any req is high: pick the winner, latch its addr/wdata/we into internal registers, set owner, load counter=WAIT_STATES, go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration (default): fixed priority; the CPU wins when both requests are high on the same edge. Sustained CPU traffic can starve DMA; this is accepted for the default build.
- ACCESS: lasts WAIT_STATES+1 cycles.
  - mem_addr and mem_wdata are driven from the latched registers for the whole state.
  - Read: mem_re=1 in every ACCESS cycle.
  - Write: mem_we=1 only in the first ACCESS cycle, 0 afterwards.
  - The counter decrements each cycle. When counter==0, go to RESP at the next edge; on that edge, for a read, capture mem_rdata into the owner's rdata register.
- RESP: exactly one cycle.
  - The owner's ack=1; the other port's ack=0.
  - Go to IDLE at the next edge.
- Latency: request sampled at edge N, ack high in cycle N+WAIT_STATES+2.
  - Back-to-back throughput is one access per WAIT_STATES+3 cycles, because IDLE always lasts at least one cycle.
- Handshake:
  - A requester must deassert req at the edge ending its ack cycle. A req still high in IDLE is a new request.
  - req is ignored outside IDLE. Dropping req mid-access does not abort; the access completes and ack still pulses.
  - addr/wdata/we may change after the grant edge without effect.
- rdata: each port's rdata holds its last read result. Writes and the other port's accesses do not alter it.
- A write followed by a read of the same address by either port returns the written data; no write buffering.
- WAIT_STATES=0: ACCESS is one cycle; latency 2.

Optional Feature:
- Macro ARB_RR_EN.
- When defined: round-robin priority. If both requests are high in IDLE, grant the port that did not receive the previous grant (owner is inverted). A single request is granted regardless. After reset, CPU has priority.
- When undefined: fixed CPU priority as above.

Test Plan:
- CPU read addr 0x005 (RAM=0x12345678), WAIT_STATES=1, req at edge 0 -> mem_re high in cycles 1–2; cpu_ack in cycle 3; cpu_rdata=0x12345678; cpu_stall high in cycles 0–2; dma_ack never asserts.
- DMA write 0x0AA←0xDEADBEEF -> mem_we high only in cycle 1; dma_ack in cycle 3. A following CPU read of 0x0AA returns 0xDEADBEEF; dma_rdata unchanged (0).
- cpu_req and dma_req both rise at edge 0, default build -> owner=0, cpu_ack in cycle 3; DMA granted at the end of IDLE cycle 4, owner=1, dma_ack in cycle 7.
- Both ports request continuously for 4 transactions -> default build: four cpu_acks, zero dma_acks. With ARB_RR_EN: grant order CPU, DMA, CPU, DMA.
- reset_n pulsed low during the first ACCESS cycle of a CPU write -> mem_we falls immediately, no cpu_ack, busy=0. After release, a new CPU read completes in WAIT_STATES+2 cycles.
- cpu_req dropped in the first ACCESS cycle of a read of 0x010 (RAM=0x0000BEEF) -> cpu_ack still pulses in cycle 3 and cpu_rdata=0x0000BEEF; the arbiter stays in IDLE afterwards.
